// File: rtl/pcap_dma_buffer.sv
// pcap_dma_buffer
//   Buffers the 32-bit capture stream from pcap_core in an on-chip FIFO and
//   hands it to the DMA writer in fixed-size blocks using a request/ack
//   handshake. A final partial block is flushed after pcap_done_i, and
//   irq_done_o pulses once that flush has drained.
//
// Ports
//   clk_i, reset_i       : clock, asynchronous active-low reset
//   arm_i                : clears sticky overflow and any pending done
//   pcap_dat_i/_valid_i  : capture word and write strobe
//   pcap_done_i          : capture finished, flush remaining words
//   dma_full_o           : registered almost-full back-pressure
//   dma_req_o/dma_len_o  : block request and its word count
//   dma_ack_i            : DMA accepts the pending request
//   dma_dat_o/dma_rd_i   : first-word-fall-through head word and pop strobe
//   fill_level_o         : current FIFO word count
//   overflow_o           : sticky, a word was dropped on a full FIFO
//   irq_done_o           : one-cycle pulse, final block drained
module pcap_dma_buffer #(
    parameter int unsigned FIFO_AW      = 10,
    parameter int unsigned BLOCK_WORDS  = 256,
    parameter int unsigned AFULL_MARGIN = 16
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               arm_i,
    input  logic [31:0]        pcap_dat_i,
    input  logic               pcap_dat_valid_i,
    input  logic               pcap_done_i,
    output logic               dma_full_o,
    output logic               dma_req_o,
    output logic [FIFO_AW:0]   dma_len_o,
    input  logic               dma_ack_i,
    output logic [31:0]        dma_dat_o,
    input  logic               dma_rd_i,
    output logic [FIFO_AW:0]   fill_level_o,
    output logic               overflow_o,
    output logic               irq_done_o
);

    localparam int unsigned DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] C_DEPTH  = (FIFO_AW+1)'(DEPTH);
    localparam logic [FIFO_AW:0] C_BLOCK  = (FIFO_AW+1)'(BLOCK_WORDS);
    localparam logic [FIFO_AW:0] C_MARGIN = (FIFO_AW+1)'(AFULL_MARGIN);

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_XFER} state_t;

    state_t               r_state, w_state_nxt;
    logic [31:0]          r_mem [DEPTH];
    logic [FIFO_AW-1:0]   r_wptr, r_rptr;
    logic [FIFO_AW:0]     r_count, r_len, r_remaining, w_len_nxt;
    logic                 r_done_pending, r_flush_flag, r_overflow, r_irq, r_afull;
    logic                 w_full, w_pop, w_push, w_drop;
    logic                 w_start_flush, w_irq_idle, w_irq_xfer;

    // Pops only count inside a granted transfer with words still owed.
    assign w_full = (r_count == C_DEPTH);
    assign w_pop  = (r_state == ST_XFER) && dma_rd_i && (r_remaining != '0);
    // A same-cycle pop frees a slot, so a write on a full FIFO is still taken.
    assign w_push = pcap_dat_valid_i && (!w_full || w_pop);
    assign w_drop = pcap_dat_valid_i && w_full && !w_pop;

    always_comb begin
        w_state_nxt   = r_state;
        w_len_nxt     = r_len;
        w_start_flush = 1'b0;
        w_irq_idle    = 1'b0;
        w_irq_xfer    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // Full blocks take priority over a pending flush.
                if (r_count >= C_BLOCK) begin
                    w_state_nxt = ST_REQ;
                    w_len_nxt   = C_BLOCK;
                end else if (r_done_pending && (r_count != '0)) begin
                    w_state_nxt   = ST_REQ;
                    w_len_nxt     = r_count;
                    w_start_flush = 1'b1;
                end else if (r_done_pending) begin
                    w_irq_idle = 1'b1;
                end
            end
            ST_REQ: begin
                if (dma_ack_i) w_state_nxt = ST_XFER;
            end
            ST_XFER: begin
                if (w_pop && (r_remaining == (FIFO_AW+1)'(1))) begin
                    w_state_nxt = ST_IDLE;
                    w_irq_xfer  = r_flush_flag;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_state        <= ST_IDLE;
            r_wptr         <= '0;
            r_rptr         <= '0;
            r_count        <= '0;
            r_len          <= '0;
            r_remaining    <= '0;
            r_done_pending <= 1'b0;
            r_flush_flag   <= 1'b0;
            r_overflow     <= 1'b0;
            r_irq          <= 1'b0;
            r_afull        <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_len   <= w_len_nxt;
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if ((r_state == ST_REQ) && dma_ack_i) r_remaining <= r_len;
            else if (w_pop)                       r_remaining <= r_remaining - 1'b1;
            // A new done wins over any same-cycle clear, including arm_i.
            if (pcap_done_i)                                r_done_pending <= 1'b1;
            else if (arm_i || w_start_flush || w_irq_idle)  r_done_pending <= 1'b0;
            if (w_start_flush)   r_flush_flag <= 1'b1;
            else if (w_irq_xfer) r_flush_flag <= 1'b0;
            if (w_drop)     r_overflow <= 1'b1;
            else if (arm_i) r_overflow <= 1'b0;
            r_irq   <= w_irq_idle || w_irq_xfer;
            r_afull <= ((C_DEPTH - r_count) <= C_MARGIN);
        end
    end

    // Storage is not reset; the empty check below masks stale contents.
    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wptr] <= pcap_dat_i;
    end

    assign dma_dat_o    = (r_count == '0) ? '0 : r_mem[r_rptr];
    assign dma_req_o    = (r_state == ST_REQ);
    assign dma_len_o    = r_len;
    assign fill_level_o = r_count;
    assign overflow_o   = r_overflow;
    assign irq_done_o   = r_irq;
    assign dma_full_o   = r_afull;

endmodule

// File: tb/tb_pcap_dma_buffer.sv
// Testbench for pcap_dma_buffer (FIFO_AW=4, BLOCK_WORDS=4, AFULL_MARGIN=2).
// Stimulus pushes expected pop data, request lengths and irq cycles into
// queues; a negedge monitor pops and compares them as the DUT presents them.
module tb_pcap_dma_buffer;

    localparam int unsigned AW = 4;

    logic          clk = 1'b0;
    logic          reset_i = 1'b1;
    logic          arm_i = 1'b0;
    logic [31:0]   pcap_dat_i = '0;
    logic          pcap_dat_valid_i = 1'b0;
    logic          pcap_done_i = 1'b0;
    logic          dma_full_o;
    logic          dma_req_o;
    logic [AW:0]   dma_len_o;
    logic          dma_ack_i = 1'b0;
    logic [31:0]   dma_dat_o;
    logic          dma_rd_i = 1'b0;
    logic [AW:0]   fill_level_o;
    logic          overflow_o;
    logic          irq_done_o;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic prev_req = 1'b0;
    int exp_dat[$];
    int exp_len[$];
    int exp_irq[$];

    pcap_dma_buffer #(.FIFO_AW(AW), .BLOCK_WORDS(4), .AFULL_MARGIN(2)) dut (
        .clk_i(clk), .reset_i(reset_i), .arm_i(arm_i),
        .pcap_dat_i(pcap_dat_i), .pcap_dat_valid_i(pcap_dat_valid_i),
        .pcap_done_i(pcap_done_i), .dma_full_o(dma_full_o),
        .dma_req_o(dma_req_o), .dma_len_o(dma_len_o), .dma_ack_i(dma_ack_i),
        .dma_dat_o(dma_dat_o), .dma_rd_i(dma_rd_i),
        .fill_level_o(fill_level_o), .overflow_o(overflow_o),
        .irq_done_o(irq_done_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic unexpected(input string name, input int act);
        checks++;
        errors++;
        $display("FAIL %s: got %0d with nothing expected", name, act);
    endtask

    // Monitor: compares DUT outputs against the scoreboard queues.
    always @(negedge clk) begin
        if (reset_i) begin
            if (dma_rd_i) begin
                if (exp_dat.size() == 0) unexpected("pop_data", int'(dma_dat_o));
                else check("pop_data", int'(dma_dat_o), exp_dat.pop_front());
            end
            if (dma_req_o && !prev_req) begin
                if (exp_len.size() == 0) unexpected("req_len", int'(dma_len_o));
                else check("req_len", int'(dma_len_o), exp_len.pop_front());
            end
            if (irq_done_o) begin
                if (exp_irq.size() == 0) unexpected("irq_cycle", cyc);
                else check("irq_cycle", cyc, exp_irq.pop_front());
            end
        end
        prev_req = dma_req_o;
    end

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic write_words(input int base, input int n, input bit done_last,
                               input int keep);
        for (int i = 0; i < n; i++) begin
            pcap_dat_valid_i = 1'b1;
            pcap_dat_i       = 32'(base + i);
            pcap_done_i      = done_last && (i == n - 1);
            if (i < keep) exp_dat.push_back(base + i);
            tick();
        end
        pcap_dat_valid_i = 1'b0;
        pcap_done_i      = 1'b0;
    endtask

    task automatic wait_req_ack();
        int n = 0;
        while (!dma_req_o && n < 50) begin
            tick();
            n++;
        end
        if (!dma_req_o) unexpected("req_timeout", n);
        dma_ack_i = 1'b1;
        tick();
        dma_ack_i = 1'b0;
    endtask

    task automatic pop_n(input int n);
        for (int i = 0; i < n; i++) begin
            dma_rd_i = 1'b1;
            tick();
        end
        dma_rd_i = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_full"},  int'(dma_full_o), 0);
        check({tag, "_req"},   int'(dma_req_o), 0);
        check({tag, "_len"},   int'(dma_len_o), 0);
        check({tag, "_dat"},   int'(dma_dat_o), 0);
        check({tag, "_fill"},  int'(fill_level_o), 0);
        check({tag, "_ovf"},   int'(overflow_o), 0);
        check({tag, "_irq"},   int'(irq_done_o), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: cycle %0d reached with run unfinished", cyc);
        $fatal(1);
    end

    initial begin
        #2 reset_i = 1'b0;
        tick(2);
        check_reset_outputs("reset");
        reset_i = 1'b1;
        tick(2);

        // Two full blocks of 4 words.
        exp_len.push_back(4);
        exp_len.push_back(4);
        write_words(1, 8, 1'b0, 8);
        check("fill_after_8", int'(fill_level_o), 8);
        wait_req_ack();
        pop_n(4);
        wait_req_ack();
        pop_n(4);
        tick(3);
        check("fill_after_blocks", int'(fill_level_o), 0);

        // 6 words with done on the last: full block then 2-word flush.
        exp_len.push_back(4);
        exp_len.push_back(2);
        write_words(11, 6, 1'b1, 6);
        wait_req_ack();
        pop_n(4);
        wait_req_ack();
        pop_n(2);
        exp_irq.push_back(cyc);
        tick(4);
        check("fill_after_flush", int'(fill_level_o), 0);

        // Done with an empty FIFO: irq only, no request.
        pcap_done_i = 1'b1;
        tick();
        pcap_done_i = 1'b0;
        exp_irq.push_back(cyc + 1);
        tick(4);
        check("req_after_empty_done", int'(dma_req_o), 0);

        // Almost-full threshold and overflow (request len 4 left unacked).
        exp_len.push_back(4);
        write_words('h100, 13, 1'b0, 13);
        tick(2);
        check("afull_at_13", int'(dma_full_o), 0);
        write_words('h10D, 1, 1'b0, 1);
        tick(2);
        check("afull_at_14", int'(dma_full_o), 1);
        write_words('h10E, 3, 1'b0, 2);
        check("ovf_after_17", int'(overflow_o), 1);
        check("fill_after_17", int'(fill_level_o), 16);
        arm_i = 1'b1;
        tick();
        arm_i = 1'b0;
        check("ovf_after_arm", int'(overflow_o), 0);
        check("fill_after_arm", int'(fill_level_o), 16);

        // Full FIFO in XFER: write plus pop in one cycle.
        wait_req_ack();
        dma_rd_i = 1'b1;
        pcap_dat_valid_i = 1'b1;
        pcap_dat_i = 32'h1FF;
        exp_dat.push_back('h1FF);
        tick();
        dma_rd_i = 1'b0;
        pcap_dat_valid_i = 1'b0;
        check("fill_full_pop_write", int'(fill_level_o), 16);
        check("ovf_full_pop_write", int'(overflow_o), 0);
        check("head_after_pop", int'(dma_dat_o), 'h101);

        // Reset mid-transfer with 3 words still owed.
        reset_i = 1'b0;
        #1;
        check_reset_outputs("midreset");
        exp_dat.delete();
        tick();
        reset_i = 1'b1;
        tick();

        exp_len.push_back(2);
        write_words('h55, 2, 1'b1, 2);
        check("fill_after_reset", int'(fill_level_o), 2);
        wait_req_ack();
        pop_n(2);
        exp_irq.push_back(cyc);
        tick(4);

        check("dat_queue_left", exp_dat.size(), 0);
        check("len_queue_left", exp_len.size(), 0);
        check("irq_queue_left", exp_irq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
